// File: rtl/fetch_pc_unit_pkg.sv
// Types and defaults shared by the fetch unit and its decode/branchCtrl neighbours.
package fetch_pc_unit_pkg;

  localparam int unsigned FETCH_PC_W     = 8;
  localparam int unsigned FETCH_INSTR_W  = 16;
  localparam int unsigned FETCH_RESET_PC = 0;

  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction FIFO between fetch and decode: registered head, sync clear, wrap-around pointers.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A pop in the same cycle makes room for a push into a full FIFO.
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch: one outstanding imem request, FIFO toward decode,
// redirect on taken branch/jump with flush and draining of a stale in-flight response.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned PC_W     = FETCH_PC_W,
  parameter int unsigned INSTR_W  = FETCH_INSTR_W,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RESET_PC = FETCH_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_en,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  input  logic               jmp_en,
  input  logic [PC_W-1:0]    jmp_target,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic               flush
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = INSTR_W + PC_W;

  fetch_state_e  state_q;
  logic [PC_W-1:0] pc_q, req_addr_q;
  logic          outst_q;

  logic            redirect;
  logic [PC_W-1:0] target;
  logic            issue, ack_v, push, pop;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   fifo_head;

  assign redirect = !rst && (jmp_en || (br_en && br_taken));
  assign target   = jmp_en ? jmp_target : br_target;
  assign flush    = redirect;

  // New requests only from FETCH with nothing in flight; a redirect cycle never
  // issues so the target is fetched next cycle rather than the stale pc.
  assign issue = !rst && (state_q == FETCH) && !outst_q && !redirect
              && (fifo_count < CW'(DEPTH));
  assign ack_v = imem_ack && outst_q;
  assign push  = ack_v && (state_q == FETCH) && !redirect;
  assign pop   = id_valid && id_ready;

  assign imem_req  = !rst && (outst_q || issue);
  assign imem_addr = outst_q ? req_addr_q : pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= PC_W'(RESET_PC);
      req_addr_q <= PC_W'(RESET_PC);
      outst_q    <= 1'b0;
    end else begin
      if (issue) begin
        pc_q       <= pc_q + PC_W'(1);
        req_addr_q <= pc_q;
        outst_q    <= 1'b1;
      end else if (ack_v) begin
        outst_q    <= 1'b0;
      end
      if (redirect) begin
        pc_q    <= target;
        state_q <= (outst_q && !imem_ack) ? DRAIN : FETCH;
      end else if ((state_q == DRAIN) && ack_v) begin
        state_q <= FETCH;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (redirect),
    .push_i  (push),
    .wdata_i ({imem_rdata, req_addr_q}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .valid_o (id_valid),
    .count_o (fifo_count)
  );

  assign id_instr = fifo_head[EW-1:PC_W];
  assign id_pc    = fifo_head[PC_W-1:0];

endmodule
